regwrite_arbiter: RTL
=====================

# regwrite_arbiter

Shares the single register-file write port between the in-order pipeline's writeback stage and results returning from the long-latency execution unit (mul/div). Long-unit results are buffered in a small FIFO and drained into free write slots. A starvation guard can stall the pipeline so buffered results are not held off forever. Sits between the MEM/WB register, the long unit's result bus and the register file, and also drives the per-cycle commit signals.

## Interface
- DEPTH, 2: long-unit result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4: cycles a non-empty FIFO head may wait before it takes the port
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pipe_valid  in  1  WB stage holds a valid instruction
- pipe_we  in  1  that instruction writes a register
- pipe_rd  in  5  destination register
- pipe_data  in  64  write data
- pipe_pc  in  64  instruction PC
- pipe_inst  in  32  instruction word
- pipe_stall  out  1  WB instruction must hold; it does not commit this cycle
- lu_valid  in  1  long unit offers a result
- lu_ready  out  1  FIFO can accept it
- lu_rd  in  5  result destination
- lu_data  in  64  result data
- rf_we  out  1  register-file write enable
- rf_addr  out  5  write address
- rf_data  out  64  write data
- commit_valid  out  1  WB instruction retires this cycle
- commit_pc  out  64  retiring PC
- commit_inst  out  32  retiring instruction

## Operation
- FIFO entries hold {live, rd, data}. lu_ready = (count < DEPTH). A push happens on lu_valid && lu_ready. Pushes with rd==0 are dropped and not stored.
- pipe_wr = pipe_valid && pipe_we && pipe_rd != 0.
- head_wr = FIFO non-empty and head live.
- Grant, evaluated each cycle:
  - FIFO wins when head_wr and (FIFO full, or starve count == STARVE_LIMIT, or !pipe_wr).
  - Otherwise the pipeline wins when pipe_wr.
  - Otherwise there is no write.
- pipe_stall = pipe_wr && FIFO wins.
- A pipe instruction with no register write (or rd==0) never stalls.
- commit_valid = pipe_valid && !pipe_stall. commit_pc and commit_inst pass pipe_pc and pipe_inst through.
- rf_* carries the granted source. rf_we = 0 when there is no grant.
- Pop rules:
  - The head pops when it is granted.
  - A dead head (live=0) pops unconditionally without using the port.
- WAW kill: ordering is decided as follows. Every long-unit result, including one pushed in the same cycle, is older than the current WB instruction.
  - On a committing pipe_wr, every FIFO entry whose rd == pipe_rd gets live cleared at the edge.
  - A same-cycle push whose lu_rd == pipe_rd is stored dead.
- Starve counter (0..STARVE_LIMIT, saturating):
  - Increments each cycle head_wr is true and the FIFO is not granted.
  - Clears on any head pop or when the FIFO is empty.
- Push and pop in the same cycle are allowed; count is unchanged.

## Timing
- Reset (rst_n low, asynchronous) empties the FIFO and clears the starve counter.
- While rst_n is low, rf_we, pipe_stall and commit_valid are 0, lu_ready is 0, and data outputs are 0.
- After release, lu_ready = 1 from the first cycle.
- Pipe path is combinational: a write appears on rf_* in the same cycle it is granted, with 0 added latency.
- Long-unit path: a result accepted at edge N can be written at the earliest in cycle N+1.
- pipe_stall is combinational from pipe_* and FIFO state. The pipeline holds MEM/WB while it is high.
- Reset asserted mid-stream discards all buffered results. No write is issued for them.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count.

## Configuration
- REGWRITE_ARB_STARVE_EN defined: the starve counter and STARVE_LIMIT override operate as described.
- REGWRITE_ARB_STARVE_EN not defined: the counter is not built. The FIFO wins only when full or when no pipe_wr is present. STARVE_LIMIT is ignored.

## Test plan
- Idle pipe, push lu rd=5 data=0xAA → next cycle rf_we=1, rf_addr=5, rf_data=0xAA, FIFO empty after the edge.
- Push rd=7 while the pipe writes rd=3 every cycle, starve enabled, limit 4 → the pipe wins 4 cycles. In the 5th, rf_addr=7 and pipe_stall=1, commit_valid=0. In the 6th, the pipe write to rd=3 commits.
- Fill FIFO (2 pushes, pipe writing) → lu_ready=0. The next cycle the FIFO wins and pipe_stall=1. lu_ready returns to 1 after the pop.
- FIFO holds rd=9, pipe commits a write to rd=9 (data 0x11) → the entry dies and pops without a write. The final rf write to x9 is 0x11.
- Pipe instruction with pipe_we=0 while the FIFO is non-empty → commit_valid=1, pipe_stall=0, FIFO head written the same cycle.
- Assert rst_n low with 2 entries buffered → all outputs 0 immediately. After release, no write is issued and lu_ready=1.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and a small FIFO of long-unit results.
// Optional starvation guard: define REGWRITE_ARB_STARVE_EN to build the counter that forces the FIFO head onto the port.
module regwrite_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [63:0] pipe_data,
    input  logic [63:0] pipe_pc,
    input  logic [31:0] pipe_inst,
    output logic        pipe_stall,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [63:0] lu_data,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [63:0] rf_data,
    output logic        commit_valid,
    output logic [63:0] commit_pc,
    output logic [31:0] commit_inst
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic          live_q [DEPTH];
    logic [4:0]    rd_q   [DEPTH];
    logic [63:0]   data_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic pipe_wr;
    logic fifo_empty;
    logic fifo_full;
    logic head_wr;
    logic starve_hit;
    logic fifo_grant;
    logic pipe_grant;
    logic push;
    logic store;
    logic store_live;
    logic pop;

    assign pipe_wr    = pipe_valid && pipe_we && (pipe_rd != 5'd0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign head_wr    = !fifo_empty && live_q[rd_ptr];

    assign fifo_grant = head_wr && (fifo_full || starve_hit || !pipe_wr);
    assign pipe_grant = pipe_wr && !fifo_grant;

    // Long-unit results are older than the WB instruction, so a same-cycle push to the same rd is already dead.
    assign push       = lu_valid && lu_ready;
    assign store      = push && (lu_rd != 5'd0);
    assign store_live = !(pipe_grant && (lu_rd == pipe_rd));
    assign pop        = !fifo_empty && (fifo_grant || !live_q[rd_ptr]);

    assign lu_ready     = rst_n && !fifo_full;
    assign pipe_stall   = rst_n && pipe_wr && fifo_grant;
    assign commit_valid = rst_n && pipe_valid && !pipe_stall;
    assign commit_pc    = rst_n ? pipe_pc : '0;
    assign commit_inst  = rst_n ? pipe_inst : '0;

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        if (rst_n && fifo_grant) begin
            rf_we   = 1'b1;
            rf_addr = rd_q[rd_ptr];
            rf_data = data_q[rd_ptr];
        end else if (rst_n && pipe_grant) begin
            rf_we   = 1'b1;
            rf_addr = pipe_rd;
            rf_data = pipe_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(store) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: count alone decides which slots hold entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_grant && (rd_q[i] == pipe_rd)) live_q[i] <= 1'b0;
        end
        if (store) begin
            live_q[wr_ptr] <= store_live;
            rd_q[wr_ptr]   <= lu_rd;
            data_q[wr_ptr] <= lu_data;
        end
    end

`ifdef REGWRITE_ARB_STARVE_EN
    localparam int              SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if (head_wr && !fifo_grant && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign starve_hit = (starve_cnt == LIMIT);
`else
    // Without the guard the limit has no effect; this term is always false.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

endmodule
